fetch_queue_unit: RTL and testbench

Parametrised successor to the single-entry fetch stage. It holds a loadable instruction cache and a fetch PC, and fills a QUEUE_DEPTH-entry FIFO of {pc, instruction} pairs. The FIFO drains to the parse unit through a valid/ready handshake. Branch redirects are absolute-relative to a supplied branch PC, so no latency fudge is needed, and flushes replay from the oldest unconsumed instruction.

---
 rtl/fetch_queue_unit_if.sv | 35 +++
 rtl/fetch_queue_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Fetch queue bus: redirect/flush control, cache load port and the valid/ready drain to the parse unit.
interface fetch_queue_unit_if #(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned INSTR_WIDTH  = 60,
  parameter int unsigned CACHE_ADDR_W = 7,
  parameter int unsigned COUNT_W      = 3
);
  logic                    redirect_i;
  logic [PC_WIDTH-1:0]     redirectPc_i;
  logic [PC_WIDTH-1:0]     redirectOffset_i;
  logic                    redirectDirection_i;
  logic                    flush_i;
  logic                    loadEnable_i;
  logic [CACHE_ADDR_W-1:0] loadAddr_i;
  logic [INSTR_WIDTH-1:0]  loadData_i;
  logic                    ready_i;
  logic                    valid_o;
  logic [PC_WIDTH-1:0]     pc_o;
  logic [INSTR_WIDTH-1:0]  data_o;
  logic [COUNT_W-1:0]      queueCount_o;

  // Fetch unit side
  modport slave (
    input  redirect_i, redirectPc_i, redirectOffset_i, redirectDirection_i,
    input  flush_i, loadEnable_i, loadAddr_i, loadData_i, ready_i,
    output valid_o, pc_o, data_o, queueCount_o
  );

  // Driver / parse-unit side
  modport master (
    output redirect_i, redirectPc_i, redirectOffset_i, redirectDirection_i,
    output flush_i, loadEnable_i, loadAddr_i, loadData_i, ready_i,
    input  valid_o, pc_o, data_o, queueCount_o
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: instruction cache + fetch PC feeding a show-ahead FIFO of {pc, word} entries.
module fetch_queue_unit #(
  parameter int unsigned          PC_WIDTH    = 16,
  parameter int unsigned          INSTR_WIDTH = 60,
  parameter int unsigned          CACHE_DEPTH = 128,
  parameter int unsigned          QUEUE_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD  = INSTR_WIDTH'(60'h800000000800000)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  fetch_queue_unit_if.slave bus
);
  localparam int unsigned CACHE_ADDR_W = $clog2(CACHE_DEPTH);
  localparam int unsigned PTR_W        = $clog2(QUEUE_DEPTH);
  localparam int unsigned COUNT_W      = PTR_W + 1;

  logic [INSTR_WIDTH-1:0] cache_q [CACHE_DEPTH];
  logic [PC_WIDTH-1:0]    qpc_q   [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] qdata_q [QUEUE_DEPTH];

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic                   empty_c;
  logic                   full_c;
  logic                   transfer_c;
  logic                   enqueue_c;
  logic                   fetch_in_range_c;
  logic                   load_in_range_c;
  logic [INSTR_WIDTH-1:0] fetch_word_c;
  logic [PC_WIDTH-1:0]    target_c;

  // Load address range check only matters when the cache does not fill its address space
  if (CACHE_DEPTH == (32'd1 << CACHE_ADDR_W)) begin : g_load_full
    assign load_in_range_c = 1'b1;
  end else begin : g_load_part
    assign load_in_range_c = (32'(bus.loadAddr_i) < CACHE_DEPTH);
  end

  // Handshake decode, cache read and redirect target
  always_comb begin
    empty_c          = (count_q == '0);
    full_c           = (count_q == COUNT_W'(QUEUE_DEPTH));
    transfer_c       = !empty_c && bus.ready_i && !bus.redirect_i && !bus.flush_i;
    enqueue_c        = !bus.redirect_i && !bus.flush_i && (!full_c || transfer_c);
    fetch_in_range_c = (32'(fetch_pc_q) < CACHE_DEPTH);
    fetch_word_c     = NOP_WORD;
    if (fetch_in_range_c) begin
      fetch_word_c = cache_q[fetch_pc_q[CACHE_ADDR_W-1:0]];
    end
    if (bus.redirectDirection_i) begin
      target_c = bus.redirectPc_i + bus.redirectOffset_i;
    end else begin
      target_c = bus.redirectPc_i - bus.redirectOffset_i;
    end
  end

  // Next-state for fetch PC, queue pointers and occupancy
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.redirect_i) begin
      fetch_pc_d = target_c;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else if (bus.flush_i) begin
      if (!empty_c) begin
        fetch_pc_d = qpc_q[head_q];
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enqueue_c) begin
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
        tail_d     = tail_q + PTR_W'(1);
      end
      if (transfer_c) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({enqueue_c, transfer_c})
        2'b10:   count_d = count_q + COUNT_W'(1);
        2'b01:   count_d = count_q - COUNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents beyond the occupied range are don't-care
  always_ff @(posedge clock_i) begin
    if (reset_i && enqueue_c) begin
      qpc_q[tail_q]   <= fetch_pc_q;
      qdata_q[tail_q] <= fetch_word_c;
    end
  end

  // Instruction cache: cleared to NOP on reset, written by the load port otherwise
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
        cache_q[i] <= NOP_WORD;
      end
    end else if (bus.loadEnable_i && load_in_range_c) begin
      cache_q[bus.loadAddr_i] <= bus.loadData_i;
    end
  end

  // Show-ahead head presentation, zeroed when empty
  always_comb begin
    bus.valid_o      = !empty_c;
    bus.queueCount_o = count_q;
    bus.pc_o         = '0;
    bus.data_o       = '0;
    if (!empty_c) begin
      bus.pc_o   = qpc_q[head_q];
      bus.data_o = qdata_q[head_q];
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue_unit;
  localparam int unsigned PC_WIDTH     = 16;
  localparam int unsigned INSTR_WIDTH  = 60;
  localparam int unsigned CACHE_DEPTH  = 128;
  localparam int unsigned QUEUE_DEPTH  = 4;
  localparam int unsigned CACHE_ADDR_W = 7;
  localparam int unsigned COUNT_W      = 3;
  localparam logic [59:0] NOP    = 60'h800000000800000;
  localparam logic [15:0] RST_PC = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [59:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_queue_unit_if #(
    .PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH),
    .CACHE_ADDR_W(CACHE_ADDR_W), .COUNT_W(COUNT_W)
  ) bus ();

  fetch_queue_unit #(
    .PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH), .CACHE_DEPTH(CACHE_DEPTH),
    .QUEUE_DEPTH(QUEUE_DEPTH), .RESET_PC(RST_PC), .NOP_WORD(NOP)
  ) dut (
    .clock_i(clk),
    .reset_i(rst_n),
    .bus(bus)
  );

  // Reference model state
  ent_t        mq[$];
  logic [15:0] m_pc;
  logic [59:0] m_cache [CACHE_DEPTH];

  int n_pass   = 0;
  int n_checks = 0;

  // Advance the model by one clock edge using the inputs currently applied
  function automatic void model_step();
    logic [59:0] w;
    bit          xfer;
    bit          enq;
    if (!rst_n) begin
      mq.delete();
      m_pc = RST_PC;
      for (int i = 0; i < CACHE_DEPTH; i++) m_cache[i] = NOP;
      return;
    end
    w = (int'(m_pc) < CACHE_DEPTH) ? m_cache[m_pc[6:0]] : NOP;
    if (bus.loadEnable_i) m_cache[bus.loadAddr_i] = bus.loadData_i;
    if (bus.redirect_i) begin
      mq.delete();
      m_pc = bus.redirectDirection_i ? bus.redirectPc_i + bus.redirectOffset_i
                                     : bus.redirectPc_i - bus.redirectOffset_i;
    end else if (bus.flush_i) begin
      if (mq.size() != 0) m_pc = mq[0].pc;
      mq.delete();
    end else begin
      xfer = (mq.size() != 0) && bus.ready_i;
      enq  = (mq.size() < QUEUE_DEPTH) || xfer;
      if (xfer) void'(mq.pop_front());
      if (enq) begin
        mq.push_back('{pc: m_pc, data: w});
        m_pc = m_pc + 16'd1;
      end
    end
  endfunction

  function automatic logic [79:0] exp_out();
    if (mq.size() == 0) return 80'd0;
    return {1'b1, mq[0].pc, mq[0].data, 3'(mq.size())};
  endfunction

  function automatic logic [79:0] got_out();
    return {bus.valid_o, bus.pc_o, bus.data_o, bus.queueCount_o};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.redirect_i          = 1'b0;
    bus.redirectPc_i        = '0;
    bus.redirectOffset_i    = '0;
    bus.redirectDirection_i = 1'b1;
    bus.flush_i             = 1'b0;
    bus.loadEnable_i        = 1'b0;
    bus.loadAddr_i          = '0;
    bus.loadData_i          = '0;
    bus.ready_i             = 1'b0;
  endtask

  task automatic set_redirect(input logic [15:0] pc, input logic [15:0] off, input logic dir);
    bus.redirect_i          = 1'b1;
    bus.redirectPc_i        = pc;
    bus.redirectOffset_i    = off;
    bus.redirectDirection_i = dir;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.loadEnable_i = 1'b1;
    bus.loadAddr_i   = 7'd0;
    bus.loadData_i   = 60'h123456789abcdef;
    bus.ready_i      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (got_out() !== 80'd0) $display("FAIL reset cyc%0d: got %h want %h", i, got_out(), 80'd0);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    rst_n       = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_redirect(16'd0, 16'd0, 1'b1);
      bus.loadEnable_i = 1'b1;
      bus.loadAddr_i   = 7'(i);
      bus.loadData_i   = {28'($urandom), 32'($urandom)};
      step();
      n_checks++;
      if (got_out() !== exp_out()) $display("FAIL basic_load cyc%0d: got %h want %h", i, got_out(), exp_out());
      else n_pass++;
    end
    idle_inputs();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (got_out() !== exp_out()) $display("FAIL basic_seq cyc%0d: got %h want %h", i, got_out(), exp_out());
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    set_redirect(16'd0, 16'd0, 1'b1);
    step();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (got_out() !== exp_out()) $display("FAIL stall cyc%0d: got %h want %h", i, got_out(), exp_out());
      else n_pass++;
    end
    n_checks++;
    if (bus.queueCount_o !== 3'd4) $display("FAIL stall_count: got %0d want 4", bus.queueCount_o);
    else n_pass++;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.pc_o !== 16'(i)) $display("FAIL stall_drain pc%0d: got %h want %h", i, bus.pc_o, 16'(i));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_redirect();
    idle_inputs();
    bus.ready_i = 1'b1;
    set_redirect(16'd0, 16'd10, 1'b1);
    step();
    bus.redirect_i = 1'b0;
    step();
    n_checks++;
    if (bus.pc_o !== 16'd10) $display("FAIL redir_head: got %h want %h", bus.pc_o, 16'd10);
    else n_pass++;
    set_redirect(16'd10, 16'd5, 1'b1);
    step();
    n_checks++;
    if (got_out() !== exp_out()) $display("FAIL redir_fwd_empty: got %h want %h", got_out(), exp_out());
    else n_pass++;
    bus.redirect_i = 1'b0;
    step();
    n_checks++;
    if (bus.pc_o !== 16'd15 || bus.valid_o !== 1'b1) $display("FAIL redir_fwd_pc: got %h want %h", bus.pc_o, 16'd15);
    else n_pass++;
    set_redirect(16'd10, 16'd12, 1'b0);
    step();
    bus.redirect_i = 1'b0;
    step();
    n_checks++;
    if ({bus.pc_o, bus.data_o} !== {16'hFFFE, NOP}) $display("FAIL redir_back_wrap: got %h/%h want %h/%h", bus.pc_o, bus.data_o, 16'hFFFE, NOP);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (got_out() !== exp_out()) $display("FAIL redir_wrap cyc%0d: got %h want %h", i, got_out(), exp_out());
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    set_redirect(16'd0, 16'd6, 1'b1);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    bus.flush_i = 1'b1;
    step();
    n_checks++;
    if (got_out() !== 80'd0) $display("FAIL flush_empty: got %h want %h", got_out(), 80'd0);
    else n_pass++;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.pc_o !== 16'(6 + i)) $display("FAIL flush_replay pc%0d: got %h want %h", i, bus.pc_o, 16'(6 + i));
      else n_pass++;
      step();
    end
    bus.flush_i = 1'b1;
    set_redirect(16'd18, 16'd2, 1'b1);
    step();
    idle_inputs();
    bus.ready_i = 1'b1;
    step();
    n_checks++;
    if (bus.pc_o !== 16'd20) $display("FAIL flush_vs_redirect: got %h want %h", bus.pc_o, 16'd20);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] addr;
    logic [59:0] neww;
    idle_inputs();
    set_redirect(16'd0, 16'd0, 1'b1);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (got_out() !== exp_out() || bus.queueCount_o !== 3'd4) $display("FAIL full_throughput cyc%0d: got %h want %h", i, got_out(), exp_out());
      else n_pass++;
    end
    addr             = m_pc;
    neww             = {28'($urandom), 32'($urandom)};
    bus.loadEnable_i = 1'b1;
    bus.loadAddr_i   = addr[6:0];
    bus.loadData_i   = neww;
    step();
    bus.loadEnable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (got_out() !== exp_out()) $display("FAIL load_old cyc%0d: got %h want %h", i, got_out(), exp_out());
      else n_pass++;
    end
    set_redirect(addr, 16'd0, 1'b1);
    step();
    bus.redirect_i = 1'b0;
    step();
    n_checks++;
    if ({bus.pc_o, bus.data_o} !== {addr, neww}) $display("FAIL load_new: got %h/%h want %h/%h", bus.pc_o, bus.data_o, addr, neww);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    set_redirect(16'd0, 16'd0, 1'b1);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (bus.queueCount_o !== 3'd3) $display("FAIL rst_mid_pre: got %0d want 3", bus.queueCount_o);
    else n_pass++;
    rst_n       = 1'b0;
    bus.ready_i = 1'b1;
    step();
    n_checks++;
    if ({bus.valid_o, bus.pc_o, bus.data_o} !== 77'd0) $display("FAIL rst_mid_clear: got %h want 0", {bus.valid_o, bus.pc_o, bus.data_o});
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({bus.valid_o, bus.pc_o, bus.data_o} !== {1'b1, RST_PC, NOP}) $display("FAIL rst_mid_first: got %h want %h", {bus.valid_o, bus.pc_o, bus.data_o}, {1'b1, RST_PC, NOP});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      rst_n       = ($urandom_range(0, 99) != 0);
      bus.ready_i = 1'($urandom);
      if ($urandom_range(0, 19) == 0) set_redirect(16'($urandom_range(0, 140)), 16'($urandom_range(0, 20)), 1'($urandom));
      bus.flush_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.loadEnable_i = 1'b1;
        bus.loadAddr_i   = 7'($urandom);
        bus.loadData_i   = {28'($urandom), 32'($urandom)};
      end
      step();
      n_checks++;
      if (got_out() !== exp_out()) $display("FAIL random cyc%0d: got %h want %h", i, got_out(), exp_out());
      else n_pass++;
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
